// File: rtl/sreg_sp_ctx_pkg.sv
// Shared constants for the status-register / stack-pointer block:
// SREG bit positions, SREG reset value and the context-level width helper.
package sreg_sp_ctx_pkg;

  localparam int SREG_C = 0;
  localparam int SREG_Z = 1;
  localparam int SREG_N = 2;
  localparam int SREG_V = 3;
  localparam int SREG_S = 4;
  localparam int SREG_H = 5;
  localparam int SREG_T = 6;
  localparam int SREG_I = 7;

  localparam logic [7:0] SREG_RST = 8'h00;

  // Bits needed to count 0..depth valid shadow entries.
  function automatic int ctx_lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sreg_sp_ctx_lifo.sv
// Shadow SREG context stack: DEPTH x 8 LIFO with push/pop, top-of-stack
// peek, level count and full/empty. Storage itself is not reset.
module ctx_lifo #(
  parameter int DEPTH = 4,
  parameter int LW    = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    top,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  // Sized to the index range so the level can address it without extension.
  logic [7:0]    mem [0:(1<<LW)-1];
  logic [LW-1:0] level_q;
  logic [LW-1:0] top_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;
  assign top_idx = level_q - LW'(1);
  assign top     = empty ? 8'h00 : mem[top_idx];
  assign level   = level_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_q <= '0;
    end else if (do_push) begin
      level_q <= level_q + LW'(1);
    end else if (do_pop) begin
      level_q <= level_q - LW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[level_q] <= wdata;
    end
  end

endmodule

// File: rtl/sreg_sp_ctx.sv
// Status register + stack pointer with shadow SREG context LIFO.
// Optional stack-limit fault is built only when SP_LIMIT_CHECK_EN is defined.
module sreg_sp_ctx
  import sreg_sp_ctx_pkg::*;
#(
  parameter int          SP_WIDTH  = 16,
  parameter logic [15:0] SP_RESET  = 16'h04ff,
  parameter logic [15:0] SP_LIMIT  = 16'h0100,
  parameter int          CTX_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  flag_we,
  input  logic [7:0]  flag_new,
  input  logic        mm_sreg_we,
  input  logic        mm_sp_l_we,
  input  logic        mm_sp_h_we,
  input  logic [7:0]  mm_io_wdata,
  input  logic        sp_upd_en,
  input  logic [15:0] sp_upd_val,
  input  logic        irq_det,
  input  logic        irq_ret,
  input  logic        sp_fault_clr,
  output logic [15:0] sp,
  output logic [7:0]  sreg,
  output logic [4:0]  ctx_level,
  output logic        ctx_err,
  output logic        sp_fault
);

  localparam int          LW      = ctx_lvl_w(CTX_DEPTH);
  localparam logic [15:0] SP_MASK = 16'((32'd1 << SP_WIDTH) - 32'd1);

  logic [15:0]   sp_q, sp_d, sp_raw;
  logic          sp_wr;
  logic [7:0]    sreg_q, sreg_d, sreg_base;
  logic          err_q, err_d;
  logic          lifo_push, lifo_pop, lifo_full, lifo_empty;
  logic [7:0]    lifo_top;
  logic [LW-1:0] lifo_level;

  // Stack pointer: memory-mapped byte writes beat the pointer unit.
  always_comb begin
    sp_raw = sp_q;
    if (mm_sp_l_we || mm_sp_h_we) begin
      if (mm_sp_l_we) sp_raw[7:0]  = mm_io_wdata;
      if (mm_sp_h_we) sp_raw[15:8] = mm_io_wdata;
    end else if (sp_upd_en) begin
      sp_raw = sp_upd_val;
    end
    sp_d  = sp_raw & SP_MASK;
    sp_wr = mm_sp_l_we || mm_sp_h_we || sp_upd_en;
  end

  // Ordinary flag update; this is also the value saved on interrupt entry.
  assign sreg_base = mm_sreg_we ? mm_io_wdata
                                : ((flag_we & flag_new) | (~flag_we & sreg_q));

  assign lifo_push = irq_det && !irq_ret;
  assign lifo_pop  = irq_ret && !irq_det;

  always_comb begin
    sreg_d = sreg_base;
    err_d  = err_q;
    if (irq_det && irq_ret) begin
      if (!lifo_empty) sreg_d = lifo_top;
      else             err_d  = 1'b1;
      sreg_d[SREG_I] = 1'b0;
    end else if (irq_det) begin
      if (lifo_full) err_d = 1'b1;
      sreg_d[SREG_I] = 1'b0;
    end else if (irq_ret) begin
      if (!lifo_empty) sreg_d = lifo_top;
      else             err_d  = 1'b1;
      sreg_d[SREG_I] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sp_q   <= SP_RESET & SP_MASK;
      sreg_q <= SREG_RST;
      err_q  <= 1'b0;
    end else begin
      sp_q   <= sp_d;
      sreg_q <= sreg_d;
      err_q  <= err_d;
    end
  end

  ctx_lifo #(
    .DEPTH (CTX_DEPTH),
    .LW    (LW)
  ) u_ctx_lifo (
    .clock (clock),
    .reset (reset),
    .push  (lifo_push),
    .pop   (lifo_pop),
    .wdata (sreg_base),
    .top   (lifo_top),
    .level (lifo_level),
    .full  (lifo_full),
    .empty (lifo_empty)
  );

`ifdef SP_LIMIT_CHECK_EN
  logic fault_q, fault_set;

  // A violating write in the same cycle as a clear keeps the fault set.
  assign fault_set = sp_wr && (sp_d < SP_LIMIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_set || (fault_q && !sp_fault_clr);
  end

  assign sp_fault = fault_q;
`else
  logic [17:0] unused_fault_cfg;
  assign unused_fault_cfg = {sp_wr, sp_fault_clr, SP_LIMIT};
  assign sp_fault         = 1'b0;
`endif

  assign sp        = sp_q;
  assign sreg      = sreg_q;
  assign ctx_level = 5'(lifo_level);
  assign ctx_err   = err_q;

endmodule

// File: tb/tb_sreg_sp_ctx.sv
// Table-driven bench for sreg_sp_ctx (SP_WIDTH=12, CTX_DEPTH=2) with an
// expected-value queue; fault expectations follow SP_LIMIT_CHECK_EN.
module tb_sreg_sp_ctx;

  localparam int SP_WIDTH  = 12;
  localparam int CTX_DEPTH = 2;
`ifdef SP_LIMIT_CHECK_EN
  localparam logic FLT = 1'b1;
`else
  localparam logic FLT = 1'b0;
`endif

  logic        clock, reset;
  logic [7:0]  flag_we, flag_new, mm_io_wdata;
  logic        mm_sreg_we, mm_sp_l_we, mm_sp_h_we;
  logic        sp_upd_en, irq_det, irq_ret, sp_fault_clr;
  logic [15:0] sp_upd_val, sp;
  logic [7:0]  sreg;
  logic [4:0]  ctx_level;
  logic        ctx_err, sp_fault;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [7:0]  fwe, fnew;
    logic        msw, ml, mh;
    logic [7:0]  wd;
    logic        ue;
    logic [15:0] uv;
    logic        det, ret, clr;
    logic [15:0] e_sp;
    logic [7:0]  e_sreg;
    logic [4:0]  e_lvl;
    logic        e_err, e_flt;
  } vec_t;

  vec_t        vt[$];
  logic [30:0] exp_q[$];

  sreg_sp_ctx #(
    .SP_WIDTH  (SP_WIDTH),
    .SP_RESET  (16'h04ff),
    .SP_LIMIT  (16'h0100),
    .CTX_DEPTH (CTX_DEPTH)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flag_we      (flag_we),
    .flag_new     (flag_new),
    .mm_sreg_we   (mm_sreg_we),
    .mm_sp_l_we   (mm_sp_l_we),
    .mm_sp_h_we   (mm_sp_h_we),
    .mm_io_wdata  (mm_io_wdata),
    .sp_upd_en    (sp_upd_en),
    .sp_upd_val   (sp_upd_val),
    .irq_det      (irq_det),
    .irq_ret      (irq_ret),
    .sp_fault_clr (sp_fault_clr),
    .sp           (sp),
    .sreg         (sreg),
    .ctx_level    (ctx_level),
    .ctx_err      (ctx_err),
    .sp_fault     (sp_fault)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(input string n, input logic rst,
                     input logic [7:0] fwe, input logic [7:0] fnew,
                     input logic msw, input logic ml, input logic mh, input logic [7:0] wd,
                     input logic ue, input logic [15:0] uv,
                     input logic det, input logic ret, input logic clr,
                     input logic [15:0] e_sp, input logic [7:0] e_sreg,
                     input logic [4:0] e_lvl, input logic e_err, input logic e_flt);
    vec_t v;
    v.name = n; v.rst = rst; v.fwe = fwe; v.fnew = fnew;
    v.msw = msw; v.ml = ml; v.mh = mh; v.wd = wd; v.ue = ue; v.uv = uv;
    v.det = det; v.ret = ret; v.clr = clr;
    v.e_sp = e_sp; v.e_sreg = e_sreg; v.e_lvl = e_lvl; v.e_err = e_err; v.e_flt = e_flt;
    vt.push_back(v);
  endtask

  task automatic idle_inputs();
    flag_we = 8'h00; flag_new = 8'h00; mm_sreg_we = 1'b0; mm_sp_l_we = 1'b0;
    mm_sp_h_we = 1'b0; mm_io_wdata = 8'h00; sp_upd_en = 1'b0; sp_upd_val = 16'h0000;
    irq_det = 1'b0; irq_ret = 1'b0; sp_fault_clr = 1'b0;
  endtask

  task automatic check(input string n, input string field, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", n, field, act, exp);
    end
  endtask

  // Driver: one vector per cycle, result checked on the following negedge.
  task automatic drive(input vec_t v);
    exp_q.push_back({v.e_sp, v.e_sreg, v.e_lvl, v.e_err, v.e_flt});
    if (v.rst) begin
      idle_inputs();
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
    end else begin
      flag_we = v.fwe; flag_new = v.fnew; mm_sreg_we = v.msw; mm_sp_l_we = v.ml;
      mm_sp_h_we = v.mh; mm_io_wdata = v.wd; sp_upd_en = v.ue; sp_upd_val = v.uv;
      irq_det = v.det; irq_ret = v.ret; sp_fault_clr = v.clr;
      @(posedge clock);
      #1 idle_inputs();
    end
    @(negedge clock);
    score(v.name);
  endtask

  // Scoreboard
  task automatic score(input string n);
    logic [30:0] e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s.queue: got empty expected entry", n);
      return;
    end
    e = exp_q.pop_front();
    check(n, "sp",        sp,                 e[30:15]);
    check(n, "sreg",      {8'h00, sreg},      {8'h00, e[14:7]});
    check(n, "ctx_level", {11'h000, ctx_level}, {11'h000, e[6:2]});
    check(n, "ctx_err",   {15'h0000, ctx_err},  {15'h0000, e[1]});
    check(n, "sp_fault",  {15'h0000, sp_fault}, {15'h0000, e[0]});
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    //   name        rst fwe    fnew  msw ml mh wd     ue uv        det ret clr  e_sp      e_sreg lvl  err flt
    add("reset",      1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h04ff, 8'h00, 5'd0, 0, 0);
    add("sph_ff",     0, 8'h00, 8'h00, 0, 0, 1, 8'hff, 0, 16'h0000, 0, 0, 0, 16'h0fff, 8'h00, 5'd0, 0, 0);
    add("spl_34",     0, 8'h00, 8'h00, 0, 1, 0, 8'h34, 0, 16'h0000, 0, 0, 0, 16'h0f34, 8'h00, 5'd0, 0, 0);
    add("sp_both",    0, 8'h00, 8'h00, 0, 1, 1, 8'h12, 0, 16'h0000, 0, 0, 0, 16'h0212, 8'h00, 5'd0, 0, 0);
    add("sp_upd",     0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 16'h1abc, 0, 0, 0, 16'h0abc, 8'h00, 5'd0, 0, 0);
    add("sp_prio",    0, 8'h00, 8'h00, 0, 1, 0, 8'h00, 1, 16'h0222, 0, 0, 0, 16'h0a00, 8'h00, 5'd0, 0, 0);
    add("sreg_83",    0, 8'h00, 8'h00, 1, 0, 0, 8'h83, 0, 16'h0000, 0, 0, 0, 16'h0a00, 8'h83, 5'd0, 0, 0);
    add("irq_flag",   0, 8'h02, 8'h02, 0, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 0, 16'h0a00, 8'h03, 5'd1, 0, 0);
    add("reti_83",    0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 16'h0a00, 8'h83, 5'd0, 0, 0);
    add("sreg_11",    0, 8'h00, 8'h00, 1, 0, 0, 8'h11, 0, 16'h0000, 0, 0, 0, 16'h0a00, 8'h11, 5'd0, 0, 0);
    add("irq1_clrc",  0, 8'h01, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 0, 16'h0a00, 8'h10, 5'd1, 0, 0);
    add("sreg_22",    0, 8'h00, 8'h00, 1, 0, 0, 8'h22, 0, 16'h0000, 0, 0, 0, 16'h0a00, 8'h22, 5'd1, 0, 0);
    add("irq2",       0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 0, 16'h0a00, 8'h22, 5'd2, 0, 0);
    add("sreg_a4",    0, 8'h00, 8'h00, 1, 0, 0, 8'ha4, 0, 16'h0000, 0, 0, 0, 16'h0a00, 8'ha4, 5'd2, 0, 0);
    add("irq3_full",  0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 0, 16'h0a00, 8'h24, 5'd2, 1, 0);
    add("reti_22",    0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 16'h0a00, 8'ha2, 5'd1, 1, 0);
    add("reti_10",    0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 16'h0a00, 8'h90, 5'd0, 1, 0);
    add("rst2",       1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h04ff, 8'h00, 5'd0, 0, 0);
    add("sreg_46",    0, 8'h00, 8'h00, 1, 0, 0, 8'h46, 0, 16'h0000, 0, 0, 0, 16'h04ff, 8'h46, 5'd0, 0, 0);
    add("reti_empty", 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 16'h04ff, 8'hc6, 5'd0, 1, 0);
    add("rst3",       1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h04ff, 8'h00, 5'd0, 0, 0);
    add("sreg_81",    0, 8'h00, 8'h00, 1, 0, 0, 8'h81, 0, 16'h0000, 0, 0, 0, 16'h04ff, 8'h81, 5'd0, 0, 0);
    add("irq_81",     0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 0, 16'h04ff, 8'h01, 5'd1, 0, 0);
    add("sreg_7e",    0, 8'h00, 8'h00, 1, 0, 0, 8'h7e, 0, 16'h0000, 0, 0, 0, 16'h04ff, 8'h7e, 5'd1, 0, 0);
    add("tail_chain", 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 0, 16'h04ff, 8'h01, 5'd1, 0, 0);
    add("reti_81",    0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 1, 0, 16'h04ff, 8'h81, 5'd0, 0, 0);
    add("tail_empty", 0, 8'h08, 8'h08, 0, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 0, 16'h04ff, 8'h09, 5'd0, 1, 0);
    add("rst4",       1, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h04ff, 8'h00, 5'd0, 0, 0);
    add("sp_00fe",    0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 16'h00fe, 0, 0, 0, 16'h00fe, 8'h00, 5'd0, 0, FLT);
    add("flt_hold",   0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 0, 16'h00fe, 8'h00, 5'd0, 0, FLT);
    add("set_wins",   0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 16'h00fd, 0, 0, 1, 16'h00fd, 8'h00, 5'd0, 0, FLT);
    add("flt_clr",    0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 0, 16'h0000, 0, 0, 1, 16'h00fd, 8'h00, 5'd0, 0, 0);
    add("sp_limit",   0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 16'h0100, 0, 0, 0, 16'h0100, 8'h00, 5'd0, 0, 0);
    add("sp_masked",  0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 1, 16'h10ff, 0, 0, 0, 16'h00ff, 8'h00, 5'd0, 0, FLT);
    add("clr_ok_wr",  0, 8'h00, 8'h00, 0, 0, 1, 8'h05, 0, 16'h0000, 0, 0, 1, 16'h05ff, 8'h00, 5'd0, 0, 0);

    foreach (vt[i]) drive(vt[i]);

    // Reset asserted while contexts are live discards them.
    idle_inputs();
    irq_det = 1'b1;
    @(posedge clock);
    #1 idle_inputs();
    @(negedge clock);
    check("mid_irq", "ctx_level", {11'h000, ctx_level}, 16'h0001);
    reset = 1'b1;
    #2;
    check("async_rst", "ctx_level", {11'h000, ctx_level}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    irq_ret = 1'b1;
    @(posedge clock);
    #1 idle_inputs();
    @(negedge clock);
    check("ret_after_rst", "ctx_err", {15'h0000, ctx_err}, 16'h0001);
    check("ret_after_rst", "sreg", {8'h00, sreg}, 16'h0080);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
